tribus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared W-bit tri-state bus. It grants one of N requesters ownership of the bus and asserts that requester's output enable. A registered turnaround gap guarantees that no two drivers are ever enabled in the same or adjacent cycles. It sits above the tri-state select datapath and replaces ad-hoc select/enable decoding with a handshaked, fair, bounded-burst scheme.

---
 rtl/tribus_arbiter.sv | 111 +++++++++++
 tb/tb_tribus_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tribus_arbiter.sv
// rtl/tribus_arbiter.sv - round-robin owner sequencer for a shared tri-state bus
// Grants one requester at a time with bounded bursts and a registered all-Z turnaround gap.
module tribus_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         last,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         oe,
  output logic [W-1:0]         y,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(MAXHOLD + 1);
  localparam int TW = $clog2(TURN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_TURN} state_t;

  state_t        state_q;
  logic [N-1:0]  gnt_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] rr_q;
  logic [OW-1:0] rr_d;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tc_q;
  logic          busy_q;

  logic          pick_vld;
  logic [OW-1:0] pick_idx;
  logic          release_now;
  int            idx;

  // Walk downward so the last hit wins: that is the first request at or above rr_q, with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = OW'(idx);
      end
    end
  end

  assign release_now = last[owner_q] | ~req[owner_q] | (cnt_q == CW'(MAXHOLD - 1));
  assign rr_d        = (int'(owner_q) == N - 1) ? '0 : owner_q + OW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      tc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_TURN: begin
          if (state_q == S_IDLE || tc_q == TW'(TURN - 1)) begin
            if (pick_vld) begin
              state_q <= S_BUSY;
              gnt_q   <= N'(1) << pick_idx;
              owner_q <= pick_idx;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            tc_q <= tc_q + TW'(1);
          end
        end
        S_BUSY: begin
          if (release_now) begin
            state_q <= S_TURN;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tc_q    <= '0;
            rr_q    <= rr_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign oe    = gnt_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign y     = (|gnt_q) ? din[int'(owner_q)*W +: W] : {W{1'bz}};

endmodule

// File: tb/tb_tribus_arbiter.sv
// tb/tb_tribus_arbiter.sv - checks tribus_arbiter against a behavioural owner/gap model
module tb_tribus_arbiter;
  localparam int N = 4, W = 8, TURN = 1, MAXHOLD = 4, OW = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   last  = '0;
  logic [N*W-1:0] din   = '0;
  wire  [N-1:0]   gnt;
  wire  [N-1:0]   oe;
  wire  [W-1:0]   y;
  wire            busy;
  wire  [OW-1:0]  owner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tribus_arbiter #(.N(N), .W(W), .TURN(TURN), .MAXHOLD(MAXHOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din),
    .gnt(gnt), .oe(oe), .y(y), .busy(busy), .owner(owner)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Model: current owner (-1 = nobody), beats served, remaining gap cycles, rr start point.
  int m_cur   = -1;
  int m_own   = 0;
  int m_rr    = 0;
  int m_beats = 0;
  int m_gap   = 0;
  int m_pick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur = -1; m_own = 0; m_rr = 0; m_beats = 0; m_gap = 0;
    end else if (m_cur >= 0) begin
      m_beats++;
      if (last[m_cur] || !req[m_cur] || m_beats == MAXHOLD) begin
        m_rr  = (m_cur + 1) % N;
        m_cur = -1;
        m_gap = TURN;
      end
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_gap == 0) begin
        m_pick = -1;
        for (int i = 0; i < N; i++)
          if (m_pick < 0 && req[(m_rr + i) % N]) m_pick = (m_rr + i) % N;
        if (m_pick >= 0) begin
          m_cur = m_pick; m_own = m_pick; m_beats = 0;
        end
      end
    end
  end

  logic [N-1:0] e_gnt;
  always @(negedge clk) begin
    e_gnt = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("oe", 32'(oe), 32'(e_gnt));
    check("busy", 32'(busy), 32'(m_cur >= 0));
    check("owner", 32'(owner), 32'(m_own));
    check("onehot", 32'($countones(oe) <= 1), 32'd1);
    if (m_cur >= 0) check("y", 32'(y), 32'(din[m_cur*W +: W]));
  end

  // Sequence entries are 4-bit grant values, read left to right in the hex literal.
  task automatic expect_seq(input string name, input logic [63:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 32'(gnt), 32'(seq[(n-1-i)*4 +: 4]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; req = '0; last = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    din = {8'hA5, 8'hC3, 8'h33, 8'h3C};
    req = 4'b1111;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1; req = '0;

    // single burst ending on last of the third beat
    @(negedge clk); #1; req = 4'b0001;
    @(negedge clk); check("burst_b1", 32'(gnt), 32'h1); check("burst_y", 32'(y), 32'h3C);
    @(negedge clk); check("burst_b2", 32'(gnt), 32'h1);
    @(negedge clk); check("burst_b3", 32'(gnt), 32'h1);
    #1; last = 4'b0001; req = '0;
    @(negedge clk); check("burst_gap", 32'(gnt), 32'h0);
    @(negedge clk); check("burst_idle", 32'(busy), 32'h0);
    #1; last = '0;

    do_reset();
    req = 4'b0011; last = 4'b1111;
    expect_seq("two_req", 64'h10201, 5);
    #1; req = '0;

    do_reset();
    req = 4'b0100; last = '0;
    expect_seq("maxhold", 64'h4444044440, 10);
    #1; req = '0;

    do_reset();
    req = 4'b1111; last = 4'b1111;
    expect_seq("fair", 64'h10204080102, 11);
    #1; req = '0; last = '0;
    repeat (3) @(negedge clk);
    #1; req = 4'b0010;
    @(negedge clk); check("mid_b1", 32'(gnt), 32'h2);
    @(negedge clk); check("mid_b2", 32'(gnt), 32'h2);
    #2; rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_oe", 32'(oe), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_owner", 32'(owner), 32'h0);
    @(negedge clk); #1; req = 4'b1010; rst_n = 1'b1;
    @(negedge clk); check("rr_after_reset", 32'(gnt), 32'h2);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      last = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      din  = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk); #1; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
